// File: rtl/vram_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the VRAM host write port.
package vram_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;
  localparam int BE_W       = 2;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } wr_state_e;

  // A FIFO entry is packed MSB-first as {be, addr, data}.
  function automatic int entry_width(input int aw, input int dw);
    return BE_W + aw + dw;
  endfunction

endpackage

// File: rtl/vram_writer_if.sv
// Host write-beat handshake bundle: the host drives beats, the writer returns ready.
interface vram_writer_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [BE_W-1:0]   be;

  modport master (output valid, addr, data, be, input ready);
  modport slave  (input valid, addr, data, be, output ready);

endinterface

// File: rtl/vram_wr_fifo.sv
// Single-clock synchronous FIFO holding host write beats; DEPTH must be a power of 2.
module vram_wr_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vram_writer.sv
// Host-side SRAM write port: buffers host beats, runs a linear fill engine, and
// issues SETUP/STROBE/HOLD write cycles only while the renderer leaves the bus idle.
module vram_writer
  import vram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 8,
  parameter int WE_CYCLES  = 2
) (
  input  logic              clk100_i,
  input  logic              reset_n_i,
  vram_writer_if.slave      host,
  input  logic              fill_start_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [ADDR_W-1:0] fill_len_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              fill_busy_o,
  input  logic              render_busy_i,
  input  logic              hsync_starting_i,
  output logic              bus_own_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_dout_o,
  output logic              ram_ce_o,
  output logic              ram_oe_o,
  output logic              ram_we_o,
  output logic              ram_lb_o,
  output logic              ram_hb_o
);

  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);
  localparam int CNT_W   = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

  wr_state_e         state_q, state_d;
  logic [CNT_W-1:0]  we_cnt_q, we_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              lb_q, lb_d, hb_q, hb_d;
  logic              src_fill_q, src_fill_d;
  logic              fill_busy_q, fill_busy_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [ADDR_W-1:0] fill_rem_q, fill_rem_d;
  logic [DATA_W-1:0] fill_data_q, fill_data_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;
  logic [BE_W-1:0]    head_be;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               bus_free;

  assign fifo_push  = host.valid && host.ready;
  assign fifo_wdata = {host.be, host.addr, host.data};
  assign head_be    = fifo_rdata[ENTRY_W-1 -: BE_W];
  assign head_addr  = fifo_rdata[DATA_W +: ADDR_W];
  assign head_data  = fifo_rdata[DATA_W-1:0];
  assign bus_free   = !render_busy_i && !hsync_starting_i;

  vram_wr_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk100_i),
    .rst_ni (reset_n_i),
    .push_i (fifo_push),
    .data_i (fifo_wdata),
    .pop_i  (fifo_pop),
    .data_o (fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    we_cnt_d    = we_cnt_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    lb_d        = lb_q;
    hb_d        = hb_q;
    src_fill_d  = src_fill_q;
    fill_busy_d = fill_busy_q;
    fill_addr_d = fill_addr_q;
    fill_rem_d  = fill_rem_q;
    fill_data_d = fill_data_q;
    fifo_pop    = 1'b0;

    if (fill_start_i && !fill_busy_q && (fill_len_i != '0)) begin
      fill_busy_d = 1'b1;
      fill_addr_d = fill_addr_i;
      fill_rem_d  = fill_len_i;
      fill_data_d = fill_data_i;
    end

    // The renderer only gates new starts; a cycle once in SETUP always runs to HOLD.
    case (state_q)
      IDLE: begin
        if (bus_free && fill_busy_q && (fill_rem_q != '0)) begin
          state_d     = SETUP;
          addr_d      = fill_addr_q;
          dout_d      = fill_data_q;
          lb_d        = 1'b1;
          hb_d        = 1'b1;
          src_fill_d  = 1'b1;
          fill_addr_d = fill_addr_q + ADDR_W'(1);
          fill_rem_d  = fill_rem_q - ADDR_W'(1);
        end else if (bus_free && !fill_busy_q && !fifo_empty) begin
          state_d    = SETUP;
          fifo_pop   = 1'b1;
          addr_d     = head_addr;
          dout_d     = head_data;
          lb_d       = head_be[0];
          hb_d       = head_be[1];
          src_fill_d = 1'b0;
        end
      end
      SETUP: begin
        state_d  = STROBE;
        we_cnt_d = '0;
      end
      STROBE: begin
        if (we_cnt_q == CNT_W'(WE_CYCLES - 1)) state_d = HOLD;
        else we_cnt_d = we_cnt_q + CNT_W'(1);
      end
      HOLD: begin
        state_d = IDLE;
        if (src_fill_q && (fill_rem_q == '0)) fill_busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      we_cnt_q    <= '0;
      addr_q      <= '0;
      dout_q      <= '0;
      lb_q        <= 1'b0;
      hb_q        <= 1'b0;
      src_fill_q  <= 1'b0;
      fill_busy_q <= 1'b0;
      fill_addr_q <= '0;
      fill_rem_q  <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      we_cnt_q    <= we_cnt_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      lb_q        <= lb_d;
      hb_q        <= hb_d;
      src_fill_q  <= src_fill_d;
      fill_busy_q <= fill_busy_d;
      fill_addr_q <= fill_addr_d;
      fill_rem_q  <= fill_rem_d;
      fill_data_q <= fill_data_d;
    end
  end

  assign host.ready  = !fifo_full;
  assign fill_busy_o = fill_busy_q;
  assign bus_own_o   = (state_q != IDLE);
  assign ram_ce_o    = (state_q != IDLE);
  assign ram_we_o    = (state_q == STROBE);
  assign ram_oe_o    = 1'b0;
  assign ram_addr_o  = addr_q;
  assign ram_dout_o  = dout_q;
  assign ram_lb_o    = lb_q;
  assign ram_hb_o    = hb_q;

endmodule

// File: tb/tb_vram_writer.sv
// Randomised scoreboard bench for vram_writer: stimulus pushes expected SRAM writes,
// an independent bus monitor pops and compares them as write strobes appear.
module tb_vram_writer;

  localparam int ADDR_W    = 18;
  localparam int DATA_W    = 16;
  localparam int WE_CYCLES = 2;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              lb;
    logic              hb;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fill_start = 1'b0;
  logic [ADDR_W-1:0] fill_addr = '0;
  logic [ADDR_W-1:0] fill_len = '0;
  logic [DATA_W-1:0] fill_data = '0;
  logic              render_busy = 1'b0;
  logic              hsync = 1'b0;
  logic              fill_busy, bus_own, ram_ce, ram_oe, ram_we, ram_lb, ram_hb;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  wr_t expQ[$];
  int  holdLog[$];
  int  ceRises = 0, writesSeen = 0;
  int  ceRiseCyc = 0, weRiseCyc = 0, fbFallCyc = 0;
  logic pWe = 0, pCe = 0, pRb = 0, pHs = 0, pFb = 0;
  int  weLen = 0;
  wr_t cur;
  int  accCyc, dummyCyc;
  int  w0, r0, h0;
  bit  randDone, seenBusy;

  vram_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host ();

  vram_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(8), .WE_CYCLES(WE_CYCLES)
  ) dut (
    .clk100_i(clk), .reset_n_i(rst_n), .host(host),
    .fill_start_i(fill_start), .fill_addr_i(fill_addr), .fill_len_i(fill_len),
    .fill_data_i(fill_data), .fill_busy_o(fill_busy),
    .render_busy_i(render_busy), .hsync_starting_i(hsync),
    .bus_own_o(bus_own), .ram_addr_o(ram_addr), .ram_dout_o(ram_dout),
    .ram_ce_o(ram_ce), .ram_oe_o(ram_oe), .ram_we_o(ram_we),
    .ram_lb_o(ram_lb), .ram_hb_o(ram_hb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic failNow(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Bus monitor: every SRAM write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pWe = 0; pCe = 0; pFb = 0; weLen = 0;
      end else begin
        if (ram_ce && !pCe) begin
          ceRises++;
          ceRiseCyc = cyc;
          checkOutput("start_bus_free", {pRb, pHs}, 0);
          checkOutput("bus_own_at_setup", bus_own, 1);
          checkOutput("we_low_at_setup", ram_we, 0);
          checkOutput("oe_low", ram_oe, 0);
        end
        if (ram_we && !pWe) begin
          weRiseCyc = cyc;
          weLen = 1;
          checkOutput("ce_with_we", ram_ce, 1);
          if (expQ.size() == 0) failNow("unexpected_write", 1, 0);
          else begin
            cur = expQ.pop_front();
            checkOutput("wr_addr", ram_addr, cur.addr);
            checkOutput("wr_data", ram_dout, cur.data);
            checkOutput("wr_lanes", {ram_hb, ram_lb}, {cur.hb, cur.lb});
            writesSeen++;
          end
        end else if (ram_we) weLen++;
        if (!ram_we && pWe) begin
          holdLog.push_back(cyc);
          checkOutput("we_width", weLen, WE_CYCLES);
          checkOutput("ce_in_hold", ram_ce, 1);
          checkOutput("hold_addr", ram_addr, cur.addr);
          checkOutput("hold_data", ram_dout, cur.data);
        end
        if (pFb && !fill_busy) fbFallCyc = cyc;
        pWe = ram_we; pCe = ram_ce; pFb = fill_busy;
      end
      pRb = render_busy; pHs = hsync;
    end
  end

  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [1:0] be, output int acc);
    bit ok = 0;
    acc = -1;
    host.valid = 1'b1; host.addr = a; host.data = d; host.be = be;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (host.ready) begin ok = 1; break; end
    end
    if (ok) begin
      acc = cyc;
      expQ.push_back('{addr: a, data: d, lb: be[0], hb: be[1]});
    end else failNow("ready_timeout", 0, 1);
    @(posedge clk); #1;
    host.valid = 1'b0;
  endtask

  task automatic applyFill(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] len,
                           input logic [DATA_W-1:0] d, input bit expectIgnored);
    fill_start = 1'b1; fill_addr = a; fill_len = len; fill_data = d;
    if (!expectIgnored)
      for (int i = 0; i < int'(len); i++)
        expQ.push_back('{addr: ADDR_W'(int'(a) + i), data: d, lb: 1'b1, hb: 1'b1});
    @(posedge clk); #1;
    fill_start = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !bus_own && !fill_busy) begin ok = 1; break; end
    end
    if (!ok) failNow("idle_timeout", expQ.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic waitWe();
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ram_we) begin ok = 1; break; end
    end
    if (!ok) failNow("we_timeout", 0, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    host.valid = 1'b0; host.addr = '0; host.data = '0; host.be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", host.ready, 1);
    checkOutput("rst_bus_own", bus_own, 0);
    checkOutput("rst_ce_we_oe", {ram_ce, ram_we, ram_oe}, 0);
    checkOutput("rst_fill_busy", fill_busy, 0);
    checkOutput("rst_addr_dout", {ram_addr, ram_dout}, 0);
    checkOutput("rst_lanes", {ram_hb, ram_lb}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write latency on an idle bus.
    applyStimulus(18'h00080, 16'hBEEF, 2'b11, accCyc);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t1_ce_latency", ceRiseCyc, accCyc + 2);
    checkOutput("t1_we_latency", weRiseCyc, accCyc + 3);

    // FIFO fills while the renderer holds the bus.
    w0 = writesSeen;
    r0 = ceRises;
    render_busy = 1'b1;
    for (int i = 0; i < 8; i++)
      applyStimulus(ADDR_W'(32'h100 + i), DATA_W'($urandom), 2'b11, dummyCyc);
    fork
      applyStimulus(18'h00200, 16'h9999, 2'b11, dummyCyc);
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("t2_ready_full", host.ready, 0);
        checkOutput("t2_no_ce_busy", ceRises, r0);
        @(posedge clk); #1;
        render_busy = 1'b0;
      end
    join
    waitIdle();
    checkOutput("t2_all_written", writesSeen, w0 + 9);

    // Renderer claims the bus mid-strobe.
    w0 = writesSeen;
    applyStimulus(18'h01000, 16'h1111, 2'b11, dummyCyc);
    applyStimulus(18'h01001, 16'h2222, 2'b10, dummyCyc);
    waitWe();
    @(posedge clk); #1;
    render_busy = 1'b1;
    r0 = ceRises;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("t3_blocked", ceRises, r0);
    checkOutput("t3_first_done", writesSeen, w0 + 1);
    @(posedge clk); #1;
    render_busy = 1'b0;
    waitIdle();
    checkOutput("t3_second_done", writesSeen, w0 + 2);

    // Wrapping fill, an ignored restart and host beats queued during the fill.
    w0 = writesSeen;
    h0 = holdLog.size();
    applyFill(18'h3FFFE, 18'd4, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("t4_fill_busy", fill_busy, 1);
    @(posedge clk); #1;
    applyFill(18'h01234, 18'd5, 16'hFFFF, 1'b1);
    applyStimulus(18'h00ABC, 16'h5A5A, 2'b11, dummyCyc);
    applyStimulus(18'h00ABD, 16'hA5A5, 2'b01, dummyCyc);
    waitIdle();
    checkOutput("t4_writes", writesSeen, w0 + 6);
    if (holdLog.size() > h0 + 3) checkOutput("t4_busy_clear", fbFallCyc, holdLog[h0 + 3] + 1);
    else failNow("t4_hold_log", holdLog.size(), h0 + 4);

    // Partial byte lanes and zero-length fill.
    applyStimulus(ADDR_W'($urandom), 16'h12AB, 2'b01, dummyCyc);
    applyStimulus(ADDR_W'($urandom), DATA_W'($urandom), 2'b00, dummyCyc);
    waitIdle();
    r0 = ceRises;
    seenBusy = 0;
    applyFill(18'h00100, 18'd0, 16'hAAAA, 1'b0);
    repeat (10) begin
      @(negedge clk);
      seenBusy |= fill_busy;
    end
    checkOutput("t6_zero_fill_busy", seenBusy, 0);
    checkOutput("t6_zero_fill_bus", ceRises, r0);
    @(posedge clk); #1;

    // Random beats against a randomly busy renderer.
    w0 = writesSeen;
    randDone = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          applyStimulus(ADDR_W'($urandom), DATA_W'($urandom), 2'($urandom), dummyCyc);
        end
        randDone = 1;
      end
      begin
        while (!randDone) begin
          @(posedge clk); #1;
          render_busy = ($urandom_range(0, 3) == 0);
          hsync = ($urandom_range(0, 7) == 0);
        end
      end
    join
    render_busy = 1'b0;
    hsync = 1'b0;
    waitIdle();
    checkOutput("rand_all_written", writesSeen, w0 + 60);
    w0 = writesSeen;
    applyFill(ADDR_W'($urandom), ADDR_W'($urandom_range(1, 6)), DATA_W'($urandom), 1'b0);
    waitIdle();
    checkOutput("rand_fill_done", fill_busy, 0);

    // Reset in the middle of a strobe with beats still queued.
    render_busy = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(ADDR_W'(32'h2000 + i), DATA_W'($urandom), 2'b11, dummyCyc);
    render_busy = 1'b0;
    waitWe();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_we_async", ram_we, 0);
    checkOutput("t5_ce_async", ram_ce, 0);
    checkOutput("t5_own_async", bus_own, 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = writesSeen;
    r0 = ceRises;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("t5_ready", host.ready, 1);
    checkOutput("t5_no_writes", writesSeen, w0);
    checkOutput("t5_no_ce", ceRises, r0);
    checkOutput("t5_fill_idle", fill_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
